// File: rtl/aqed_nbuf_pkg.sv
// Shared types and constants for the A-QED N-buffer tracker.
// rd_tag_t shows the tag layout for the default FRAME_W=8 / CNT_WIDTH=16 build.
package aqed_nbuf_pkg;

    localparam int BANK_W      = 2;
    localparam int FULLCNT_W   = 3;
    localparam int TAG_FRAME_W = 8;
    localparam int TAG_INDEX_W = 16;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_ARMED = 2'd1,
        CAP_DONE  = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [TAG_FRAME_W-1:0] frame;
        logic [TAG_INDEX_W-1:0] index;
    } rd_tag_t;

endpackage

// File: rtl/aqed_tag_pipe.sv
// RD_LAT-deep shift register carrying {frame, index} tags from an accepted read
// to the cycle its data comes back from the core.
module aqed_tag_pipe #(
    parameter int TAG_W  = 24,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic             head_valid,
    output logic [TAG_W-1:0] head_tag,
    output logic             consume,
    output logic             orphan
);

    logic [RD_LAT-1:0] vld;
    logic [TAG_W-1:0]  tags [RD_LAT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) tags[i] <= '0;
        end else if (en) begin
            vld[0]  <= push;
            tags[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i]  <= vld[i-1];
                tags[i] <= tags[i-1];
            end
        end
    end

    assign head_valid = vld[RD_LAT-1];
    assign head_tag   = tags[RD_LAT-1];
    // The head slot drains by shifting; pop only classifies the returning data.
    assign consume    = pop & head_valid;
    assign orphan     = pop & ~head_valid;

endmodule

// File: rtl/aqed_nbuf_tracker.sv
// A-QED tracker for an N-buffer memory core: frame/bank bookkeeping, sticky
// protocol flags, and a single captured write checked against its read-back.
module aqed_nbuf_tracker
    import aqed_nbuf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int NUM_BANKS  = 2,
    parameter int RD_LAT     = 1,
    parameter int FRAME_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic [CNT_WIDTH-1:0]  depth,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  exec_dup,
    output logic                  wr_ok,
    output logic                  rd_ok,
    output logic [BANK_W-1:0]     wr_bank,
    output logic [BANK_W-1:0]     rd_bank,
    output logic [FULLCNT_W-1:0]  full_banks,
    output logic                  qed_done,
    output logic                  qed_check,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic                  err_cfg
);

    localparam int TAG_W = FRAME_W + CNT_WIDTH;

    logic [CNT_WIDTH-1:0]  depth_q, cnt_w, cnt_r, depth_eff, last_idx, tag_i;
    logic [FRAME_W-1:0]    wr_frame, rd_frame, tag_f;
    logic [DATA_WIDTH-1:0] orig;
    logic                  cfg_dead, latch_pt, acc_w, acc_r, fill, drain;
    logic                  head_valid, consume, orphan;
    logic [TAG_W-1:0]      head_tag;
    cap_state_t            cap_state;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
    endfunction

    // At a latch point the incoming depth is already the one in force for this edge.
    assign latch_pt  = (cnt_w == '0) && (cnt_r == '0) && (full_banks == '0);
    assign depth_eff = latch_pt ? depth : depth_q;
    assign last_idx  = depth_eff - CNT_WIDTH'(1);

    assign wr_ok = !cfg_dead && (full_banks < FULLCNT_W'(NUM_BANKS));
    assign rd_ok = !cfg_dead && (full_banks != '0);
    assign acc_w = clk_en & wen & wr_ok;
    assign acc_r = clk_en & ren & rd_ok;
    assign fill  = acc_w && (cnt_w == last_idx);
    assign drain = acc_r && (cnt_r == last_idx);

    aqed_tag_pipe #(.TAG_W(TAG_W), .RD_LAT(RD_LAT)) u_tag_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (clk_en),
        .push       (acc_r),
        .push_tag   ({rd_frame, cnt_r}),
        .pop        (clk_en & rvalid),
        .head_valid (head_valid),
        .head_tag   (head_tag),
        .consume    (consume),
        .orphan     (orphan)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_q       <= '0;
            cnt_w         <= '0;
            cnt_r         <= '0;
            wr_frame      <= '0;
            rd_frame      <= '0;
            wr_bank       <= '0;
            rd_bank       <= '0;
            full_banks    <= '0;
            cfg_dead      <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_cfg       <= 1'b0;
        end else if (clk_en) begin
            if (latch_pt) depth_q <= depth;
            if (acc_w) begin
                if (fill) begin
                    cnt_w    <= '0;
                    wr_bank  <= next_bank(wr_bank);
                    wr_frame <= wr_frame + FRAME_W'(1);
                end else begin
                    cnt_w <= cnt_w + CNT_WIDTH'(1);
                end
            end
            if (acc_r) begin
                if (drain) begin
                    cnt_r    <= '0;
                    rd_bank  <= next_bank(rd_bank);
                    rd_frame <= rd_frame + FRAME_W'(1);
                end else begin
                    cnt_r <= cnt_r + CNT_WIDTH'(1);
                end
            end
            if (fill && !drain)
                full_banks <= full_banks + FULLCNT_W'(1);
            else if (drain && !fill)
                full_banks <= full_banks - FULLCNT_W'(1);
            if ((latch_pt && depth == '0) || (!latch_pt && depth != depth_q))
                err_cfg <= 1'b1;
            if (latch_pt && depth == '0)
                cfg_dead <= 1'b1;
            if (wen && !wr_ok)
                err_overflow <= 1'b1;
            if ((ren && !rd_ok) || orphan)
                err_underflow <= 1'b1;
        end
    end

    // Capture FSM: DONE is terminal so qed_done fires at most once per reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap_state <= CAP_IDLE;
            orig      <= '0;
            tag_f     <= '0;
            tag_i     <= '0;
            qed_done  <= 1'b0;
            qed_check <= 1'b0;
        end else begin
            qed_done <= 1'b0;
            case (cap_state)
                CAP_IDLE: begin
                    if (acc_w && exec_dup) begin
                        orig      <= wdata;
                        tag_f     <= wr_frame;
                        tag_i     <= cnt_w;
                        cap_state <= CAP_ARMED;
                    end
                end
                CAP_ARMED: begin
                    if (consume && head_tag == {tag_f, tag_i}) begin
                        qed_done  <= 1'b1;
                        qed_check <= (rdata == orig);
                        cap_state <= CAP_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aqed_nbuf_tracker.sv
// Bench for aqed_nbuf_tracker: directed scenarios plus random traffic, all checked
// against a word-count model (frames = words / depth) and a one-deep core model.
module tb_aqed_nbuf_tracker;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0, clk_en = 1'b0, wen = 1'b0, ren = 1'b0;
    logic          rvalid = 1'b0, exec_dup = 1'b0;
    logic [CW-1:0] depth = '0;
    logic [DW-1:0] wdata = '0, rdata = '0;
    logic          wr_ok, rd_ok, qed_done, qed_check;
    logic          err_overflow, err_underflow, err_cfg;
    logic [1:0]    wr_bank, rd_bank;
    logic [2:0]    full_banks;

    aqed_nbuf_tracker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .NUM_BANKS(NB), .RD_LAT(1), .FRAME_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .depth(depth),
        .wen(wen), .wdata(wdata), .ren(ren), .rvalid(rvalid), .rdata(rdata),
        .exec_dup(exec_dup), .wr_ok(wr_ok), .rd_ok(rd_ok), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .full_banks(full_banks), .qed_done(qed_done),
        .qed_check(qed_check), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model state: total accepted words since reset, plus sticky flags and capture.
    int      m_w, m_r, m_depth, m_cap;
    bit      m_ov, m_un, m_cfg, m_dead, m_armed, m_done, m_qdone, m_qcheck;
    logic [DW-1:0] m_orig;
    logic [DW-1:0] wlog [0:1023];
    bit      pend;
    int      pend_num;
    int      corrupt_num = -1;

    function automatic int m_full();
        if (m_depth == 0) return 0;
        return m_w / m_depth - m_r / m_depth;
    endfunction
    function automatic int m_wbank();
        return (m_depth == 0) ? 0 : (m_w / m_depth) % NB;
    endfunction
    function automatic int m_rbank();
        return (m_depth == 0) ? 0 : (m_r / m_depth) % NB;
    endfunction
    function automatic bit m_wr_ok();
        return !m_dead && m_full() < NB;
    endfunction
    function automatic bit m_rd_ok();
        return !m_dead && m_full() > 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel();
        checkOutput("wr_ok", 32'(wr_ok), 32'(m_wr_ok()));
        checkOutput("rd_ok", 32'(rd_ok), 32'(m_rd_ok()));
        checkOutput("wr_bank", 32'(wr_bank), 32'(m_wbank()));
        checkOutput("rd_bank", 32'(rd_bank), 32'(m_rbank()));
        checkOutput("full_banks", 32'(full_banks), 32'(m_full()));
        checkOutput("qed_done", 32'(qed_done), 32'(m_qdone));
        checkOutput("qed_check", 32'(qed_check), 32'(m_qcheck));
        checkOutput("err_overflow", 32'(err_overflow), 32'(m_ov));
        checkOutput("err_underflow", 32'(err_underflow), 32'(m_un));
        checkOutput("err_cfg", 32'(err_cfg), 32'(m_cfg));
    endtask

    // One clock of stimulus, then the model's view of that edge, then a full check.
    task automatic applyStimulus(input bit rst_n, input bit en, input bit w, input logic [DW-1:0] wd,
                                 input bit r, input bit dup, input int dep);
        bit okw, okr, latch, rv;
        logic [DW-1:0] rd;
        @(negedge clk);
        rv = pend;
        rd = pend ? (wlog[pend_num] ^ ((pend_num == corrupt_num) ? 16'h0001 : 16'h0000)) : '0;
        reset_n = rst_n; clk_en = en; wen = w; wdata = wd; ren = r;
        exec_dup = dup; depth = dep[CW-1:0]; rvalid = rv; rdata = rd;
        @(posedge clk);
        #1;
        m_qdone = 0;
        if (!rst_n) begin
            m_w = 0; m_r = 0; m_depth = 0; m_cap = -1;
            m_ov = 0; m_un = 0; m_cfg = 0; m_dead = 0;
            m_armed = 0; m_done = 0; m_qcheck = 0; m_orig = '0; pend = 0;
        end else if (en) begin
            latch = (m_w == m_r) && (m_depth == 0 || m_w % m_depth == 0);
            if (latch && m_w == 0) m_depth = dep;
            okw = m_wr_ok();
            okr = m_rd_ok();
            if (w && !okw) m_ov = 1;
            if (r && !okr) m_un = 1;
            if (latch && dep == 0) begin m_cfg = 1; m_dead = 1; end
            if (!latch && dep != m_depth) m_cfg = 1;
            if (rv) begin
                if (m_armed && pend_num == m_cap) begin
                    m_armed = 0; m_done = 1; m_qdone = 1; m_qcheck = (rd == m_orig);
                end
                pend = 0;
            end
            if (w && okw) begin
                if (dup && !m_armed && !m_done) begin
                    m_armed = 1; m_cap = m_w; m_orig = wd;
                end
                wlog[m_w] = wd;
                m_w++;
            end
            if (r && okr) begin
                pend = 1; pend_num = m_r; m_r++;
            end
        end
        checkModel();
    endtask

    initial begin
        // 1: fill one frame, drain it
        $display("[TB] basic fill/drain");
        applyStimulus(0, 1, 0, '0, 0, 0, 4);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 16'(16'h100 + i), 0, 0, 4);
        checkOutput("t1_full_after_wr", 32'(full_banks), 32'd1);
        checkOutput("t1_wr_bank", 32'(wr_bank), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0, 1, 0, 4);
        applyStimulus(1, 1, 0, '0, 0, 0, 4);
        checkOutput("t1_full_after_rd", 32'(full_banks), 32'd0);
        checkOutput("t1_rd_bank", 32'(rd_bank), 32'd1);
        checkOutput("t1_no_err", 32'({err_overflow, err_underflow, err_cfg}), 32'd0);

        // 2: overflow after both banks fill
        $display("[TB] overflow");
        applyStimulus(0, 1, 0, '0, 0, 0, 4);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 16'(i), 0, 0, 4);
        checkOutput("t2_wr_ok", 32'(wr_ok), 32'd0);
        applyStimulus(1, 1, 1, 16'h55, 0, 0, 4);
        checkOutput("t2_overflow", 32'(err_overflow), 32'd1);
        checkOutput("t2_full_held", 32'(full_banks), 32'd2);

        // 3: read at reset release
        $display("[TB] underflow");
        applyStimulus(0, 1, 0, '0, 0, 0, 4);
        applyStimulus(1, 1, 0, '0, 1, 0, 4);
        checkOutput("t3_underflow", 32'(err_underflow), 32'd1);
        checkOutput("t3_rd_ok", 32'(rd_ok), 32'd0);

        // 4: capture write #6, matching and corrupted read-back
        for (int pass = 0; pass < 2; pass++) begin
            $display("[TB] capture pass %0d", pass);
            corrupt_num = (pass == 1) ? 5 : -1;
            applyStimulus(0, 1, 0, '0, 0, 0, 4);
            for (int i = 0; i < 8; i++)
                applyStimulus(1, 1, 1, (i == 5) ? 16'hBEEF : 16'(16'h1000 + i), 0, (i == 5), 4);
            for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, '0, 1, 0, 4);
            applyStimulus(1, 1, 0, '0, 0, 0, 4);
            checkOutput("t4_qed_done", 32'(qed_done), 32'd1);
            checkOutput("t4_qed_check", 32'(qed_check), (pass == 0) ? 32'd1 : 32'd0);
            applyStimulus(1, 1, 0, '0, 0, 0, 4);
            checkOutput("t4_done_pulse", 32'(qed_done), 32'd0);
        end
        corrupt_num = -1;

        // 5: simultaneous fill and drain
        $display("[TB] simultaneous completion");
        applyStimulus(0, 1, 0, '0, 0, 0, 4);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 16'(i), 0, 0, 4);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 16'(16'h20 + i), 1, 0, 4);
        checkOutput("t5_full", 32'(full_banks), 32'd1);
        checkOutput("t5_banks", 32'({wr_bank, rd_bank}), 32'({2'd0, 2'd1}));

        // 6: depth change mid-frame, then reset mid-frame; then zero depth
        $display("[TB] config errors");
        applyStimulus(0, 1, 0, '0, 0, 0, 4);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1, 1, 16'(i), 0, (i == 1), 4);
        applyStimulus(1, 1, 0, '0, 0, 0, 5);
        checkOutput("t6_err_cfg", 32'(err_cfg), 32'd1);
        applyStimulus(0, 1, 0, '0, 0, 0, 4);
        checkOutput("t6_reset_cfg", 32'(err_cfg), 32'd0);
        applyStimulus(1, 1, 0, '0, 0, 0, 0);
        checkOutput("t6_zero_cfg", 32'(err_cfg), 32'd1);
        applyStimulus(1, 1, 1, 16'h1, 0, 0, 0);
        checkOutput("t6_zero_wr_ok", 32'(wr_ok), 32'd0);

        // Random traffic with clk_en gaps, occasional captures and corruption
        for (int s = 0; s < 4; s++) begin
            int dep;
            dep = int'($urandom_range(1, 5));
            corrupt_num = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
            $display("[TB] random session %0d depth=%0d", s, dep);
            applyStimulus(0, 1, 0, '0, 0, 0, dep);
            for (int i = 0; i < 300; i++)
                applyStimulus(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 6),
                              DW'($urandom), ($urandom_range(0, 9) < 6),
                              ($urandom_range(0, 19) == 0), dep);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aqed_nbuf_tracker.md
Name: aqed_nbuf_tracker

Overview:
- Synthesizable A-QED tracker for a memory core running in N-buffer (double-buffer generalised to NUM_BANKS) mode.
- Counts accepted writes and reads per frame of `depth` words, rotates write/read banks, and raises sticky protocol-violation flags.
- Captures one symbolically chosen write (`exec_dup`) and checks that the matching read returns the same data, reporting `qed_done` and `qed_check`.
- Sits beside `memory_core` in the formal top. It replaces the hand-written count_wen/count_ren logic and the resource-constraint logic.

Parameters:
- DATA_WIDTH, 16, width of write and read data.
- CNT_WIDTH, 16, width of `depth` and of the per-frame index counters.
- NUM_BANKS, 2, number of frame buffers in rotation; legal values 2..4.
- RD_LAT, 1, cycles from an accepted `ren` to its `rvalid`/`rdata`; legal values 1..4.
- FRAME_W, 8, width of the write/read frame sequence counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- clk_en  in  1  qualifies every input event.
- depth  in  CNT_WIDTH  words per frame; must be nonzero.
- wen  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- ren  in  1  read request.
- rvalid  in  1  read data valid from the core.
- rdata  in  DATA_WIDTH  read data from the core.
- exec_dup  in  1  symbolic capture select.
- wr_ok  out  1  a write is permitted this cycle.
- rd_ok  out  1  a read is permitted this cycle.
- wr_bank  out  2  bank currently being filled.
- rd_bank  out  2  bank currently being drained.
- full_banks  out  3  number of banks completely written and not yet drained.
- qed_done  out  1  one-cycle pulse when the captured word's read returns.
- qed_check  out  1  result of the compare; valid when `qed_done` is high.
- err_overflow  out  1  sticky: write attempted while not permitted.
- err_underflow  out  1  sticky: read attempted while not permitted.
- err_cfg  out  1  sticky: `depth` changed mid-frame, or `depth` is zero.

Behaviour:
- Reset (`reset_n`=0 at a clock edge): every counter, bank pointer, flag and output is cleared to 0, including `qed_done`, `qed_check` and all err_* flags. The capture FSM returns to IDLE and the tag pipe is flushed. Reset mid-operation discards in-flight reads.
- Permissions (combinational):
  - `wr_ok` = `full_banks` < NUM_BANKS.
  - `rd_ok` = `full_banks` > 0.
- Accepted write: `clk_en` & `wen` & `wr_ok`.
  - Increments `cnt_w`.
  - At `cnt_w`==`depth_q`-1: `cnt_w` returns to 0, `wr_bank` advances modulo NUM_BANKS, `wr_frame` increments, and the bank is marked full.
- Accepted read: `clk_en` & `ren` & `rd_ok`.
  - Increments `cnt_r`.
  - At `cnt_r`==`depth_q`-1: `cnt_r` returns to 0, `rd_bank` advances, `rd_frame` increments, and the bank is freed.
- Simultaneous frame completion (fill and drain in the same cycle): `full_banks` is unchanged and both pointers advance.
- Rejected events:
  - `clk_en` & `wen` & !`wr_ok` sets `err_overflow`; the write is not counted.
  - `clk_en` & `ren` & !`rd_ok` sets `err_underflow`; the read is not counted.
  - Without `clk_en`, nothing changes.
- Depth handling:
  - `depth_q` is latched from `depth` whenever `cnt_w`==0, `cnt_r`==0 and `full_banks`==0.
  - `depth` != `depth_q` in any other cycle sets `err_cfg`.
  - `depth`==0 at a latch point sets `err_cfg`; the tracker then holds `wr_ok`=`rd_ok`=0 until reset.
- Counter arithmetic: all counters are unsigned and wrap; `wr_frame`/`rd_frame` wrap at 2^FRAME_W.
- Tag pipe: every accepted read pushes {`rd_frame`, `cnt_r`} into an RD_LAT-deep shift register. The head tag is consumed when `rvalid` is high. `rvalid` without a pending tag sets `err_underflow`.
- Capture FSM, states IDLE, ARMED, DONE:
  - IDLE -> ARMED on an accepted write with `exec_dup`=1. On that edge, latch `orig`=`wdata`, `tag_f`=`wr_frame`, `tag_i`=`cnt_w`.
  - ARMED -> DONE when `rvalid` and head tag == {`tag_f`, `tag_i`}. That cycle registers `qed_done`=1 and `qed_check`=(`rdata`==`orig`), visible the cycle after.
  - DONE is terminal until reset. `qed_check` holds its value; `qed_done` pulses exactly once.
  - `exec_dup` is ignored outside IDLE and on rejected writes.

Decomposition:
- Package `aqed_nbuf_pkg`:
  - capture state enum (IDLE/ARMED/DONE);
  - packed read-tag struct {frame, index};
  - constants `BANK_W`=2 and `FULLCNT_W`=3.
- One sub-module: `aqed_tag_pipe`, the RD_LAT-deep valid/tag shift register with head output and pop.

Test Plan:
1. depth=4, NUM_BANKS=2, RD_LAT=1. Write 4 words -> `full_banks`=1, `wr_bank`=1. Read 4 words -> `full_banks`=0, `rd_bank`=1, no errors.
2. depth=4. Write 8 words with no reads -> `wr_ok`=0 after the 8th write. A 9th `wen` sets `err_overflow`=1 and `cnt_w` stays 0.
3. `ren` at reset release -> `rd_ok`=0, `err_underflow`=1, and `cnt_r` unchanged.
4. depth=4. Capture write #6 (frame 1, index 1, data 16'hBEEF). Core returns 16'hBEEF on the 6th read -> `qed_done`=1 and `qed_check`=1 one cycle later. Core returns 16'hBEEE instead -> `qed_check`=0.
5. Fill frame 1 while draining frame 0, both completing on the same edge -> `full_banks` stays 1 and both bank pointers toggle.
6. `depth` changed 4->5 after 2 writes -> `err_cfg`=1. `reset_n`=0 for one cycle mid-frame -> all outputs return to 0 and the FSM returns to IDLE.
